// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: default widths and the drain FSM encoding.
package fifo_pkg;

   localparam int unsigned FWIDTH_DEF  = 32;
   localparam int unsigned FDEPTH_DEF  = 4;
   localparam int unsigned FCWIDTH_DEF = 3;
   localparam int unsigned BWIDTH_DEF  = 8;
   localparam int unsigned CNTW_DEF    = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } drain_state_e;

   // Beat-index width; a single-beat word still needs a 1-bit index vector.
   function automatic int unsigned idx_width(input int unsigned nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/fifo_beat_mux.sv
// Selects beat idx out of a FIFO word, ordering beats MSB-first or LSB-first.
module fifo_beat_mux
   import fifo_pkg::*;
#(
   parameter int unsigned FWIDTH    = FWIDTH_DEF,
   parameter int unsigned BWIDTH    = BWIDTH_DEF,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned IDXW      = idx_width(FWIDTH / BWIDTH)
) (
   input  logic [FWIDTH-1:0] word,
   input  logic [IDXW-1:0]   idx,
   output logic [BWIDTH-1:0] beat_c
);

   localparam int unsigned NB = FWIDTH / BWIDTH;

   logic [IDXW-1:0] slot_c;

   // Map beat order onto a physical slot (slot 0 = least significant bits).
   always_comb begin
      slot_c = MSB_FIRST ? (IDXW'(NB - 1) - idx) : idx;
      beat_c = word[32'(slot_c) * BWIDTH +: BWIDTH];
   end

endmodule

// File: rtl/fifo_byte_drain.sv
// Pops words from the FIFO and streams them out as valid/ready beats; owns FIFO clear.
module fifo_byte_drain
   import fifo_pkg::*;
#(
   parameter int unsigned FWIDTH    = FWIDTH_DEF,
   parameter int unsigned BWIDTH    = BWIDTH_DEF,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned CNTW      = CNTW_DEF
) (
   input  logic              Clk,
   input  logic              RstN,
   input  logic              En,
   input  logic              FlushN,
   input  logic [FWIDTH-1:0] F_Data,
   input  logic              F_EmptyN,
   output logic              FOutN,
   output logic              FClrN,
   output logic [BWIDTH-1:0] B_Data,
   output logic              B_Valid,
   output logic              B_Last,
   input  logic              B_Ready,
   output logic              Busy,
   output logic [CNTW-1:0]   Words_Sent
);

   localparam int unsigned     NB       = FWIDTH / BWIDTH;
   localparam int unsigned     IDXW     = idx_width(NB);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

   drain_state_e      state_q, state_d;
   logic [FWIDTH-1:0] word_q, word_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [CNTW-1:0]   sent_q, sent_d;
   logic [BWIDTH-1:0] bdata_q, bdata_d;
   logic              bvalid_q, bvalid_d;
   logic              blast_q, blast_d;
   logic              pop_c;
   logic              accept_c;
   logic [BWIDTH-1:0] beat_c;

   // Beat selected from the next-cycle word/index so the output beat can be registered.
   fifo_beat_mux #(
      .FWIDTH    (FWIDTH),
      .BWIDTH    (BWIDTH),
      .MSB_FIRST (MSB_FIRST),
      .IDXW      (IDXW)
   ) u_beat_mux (
      .word   (word_d),
      .idx    (idx_d),
      .beat_c (beat_c)
   );

   // Next-state, pop decision and next registered outputs; flush overrides everything.
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      idx_d    = idx_q;
      sent_d   = sent_q;
      pop_c    = 1'b0;
      accept_c = (state_q == ST_SEND) && B_Ready;

      if (!FlushN) begin
         state_d = ST_IDLE;
         word_d  = '0;
         idx_d   = '0;
      end else if (state_q == ST_IDLE) begin
         if (En && F_EmptyN) begin
            pop_c   = 1'b1;
            word_d  = F_Data;
            idx_d   = '0;
            state_d = ST_SEND;
         end
      end else if (accept_c) begin
         if (idx_q != LAST_IDX) begin
            idx_d = idx_q + IDXW'(1);
         end else begin
            sent_d = sent_q + CNTW'(1);
            idx_d  = '0;
            if (En && F_EmptyN) begin
               // Back-to-back reload: no bubble between words.
               pop_c  = 1'b1;
               word_d = F_Data;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end

      // No pop strobe while the block is held in reset.
      pop_c = pop_c && RstN;

      bvalid_d = (state_d == ST_SEND);
      blast_d  = bvalid_d && (idx_d == LAST_IDX);
      bdata_d  = bvalid_d ? beat_c : '0;
   end

   // State, word holding register, beat index, counter and output registers.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state_q  <= ST_IDLE;
         word_q   <= '0;
         idx_q    <= '0;
         sent_q   <= '0;
         bdata_q  <= '0;
         bvalid_q <= 1'b0;
         blast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         idx_q    <= idx_d;
         sent_q   <= sent_d;
         bdata_q  <= bdata_d;
         bvalid_q <= bvalid_d;
         blast_q  <= blast_d;
      end
   end

   assign FOutN      = ~pop_c;
   assign FClrN      = FlushN | ~RstN;
   assign B_Data     = bdata_q;
   assign B_Valid    = bvalid_q;
   assign B_Last     = blast_q;
   assign Busy       = (state_q == ST_SEND);
   assign Words_Sent = sent_q;

endmodule

// File: tb/tb_fifo_byte_drain.sv
// Bench: queue-based FIFO (depth 4) feeding two drains (MSB-first and LSB-first) plus a word-level model.
module tb_fifo_byte_drain;

   localparam int unsigned FW = 32;
   localparam int unsigned BW = 8;
   localparam int unsigned NB = 4;
   localparam int unsigned CW = 16;

   logic          Clk = 1'b0;
   logic          RstN, En, FlushN, F_EmptyN, B_Ready;
   logic [FW-1:0] F_Data;

   logic          fout_m, fclr_m, valid_m, last_m, busy_m;
   logic [BW-1:0] data_m;
   logic [CW-1:0] sent_m;
   logic          fout_l, fclr_l, valid_l, last_l, busy_l;
   logic [BW-1:0] data_l;
   logic [CW-1:0] sent_l;

   always #5 Clk = ~Clk;

   fifo_byte_drain #(.FWIDTH(FW), .BWIDTH(BW), .MSB_FIRST(1'b1), .CNTW(CW)) u_msb (
      .Clk(Clk), .RstN(RstN), .En(En), .FlushN(FlushN), .F_Data(F_Data), .F_EmptyN(F_EmptyN),
      .FOutN(fout_m), .FClrN(fclr_m), .B_Data(data_m), .B_Valid(valid_m), .B_Last(last_m),
      .B_Ready(B_Ready), .Busy(busy_m), .Words_Sent(sent_m));

   fifo_byte_drain #(.FWIDTH(FW), .BWIDTH(BW), .MSB_FIRST(1'b0), .CNTW(CW)) u_lsb (
      .Clk(Clk), .RstN(RstN), .En(En), .FlushN(FlushN), .F_Data(F_Data), .F_EmptyN(F_EmptyN),
      .FOutN(fout_l), .FClrN(fclr_l), .B_Data(data_l), .B_Valid(valid_l), .B_Last(last_l),
      .B_Ready(B_Ready), .Busy(busy_l), .Words_Sent(sent_l));

   int errors = 0;
   int checks = 0;

   logic [31:0] fifo_q[$];
   bit          m_held;
   logic [31:0] m_word;
   int          m_idx;
   logic [15:0] m_count;

   logic [7:0]  log_m[$];
   logic [7:0]  log_l[$];
   logic        log_last[$];
   int          pops, tick_no, first_acc, last_acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] beat_msb(input logic [31:0] w, input int i);
      return 8'(w >> (FW - BW * (i + 1)));
   endfunction

   function automatic logic [7:0] beat_lsb(input logic [31:0] w, input int i);
      return 8'(w >> (BW * i));
   endfunction

   task automatic clear_logs();
      log_m.delete();
      log_l.delete();
      log_last.delete();
      pops = 0;
      first_acc = -1;
      last_acc = -1;
   endtask

   // One clock: present FIFO head, check strobes, advance FIFO and model at the edge, check outputs.
   task automatic tick();
      bit          exp_pop, do_pop, do_clr;
      logic [31:0] head;
      F_EmptyN = (fifo_q.size() != 0);
      F_Data   = F_EmptyN ? fifo_q[0] : 32'h0;
      #1;
      exp_pop = RstN && FlushN && En && F_EmptyN && (!m_held || (B_Ready && m_idx == NB - 1));
      chk("pop_strobe", 32'(fout_m), 32'(!exp_pop));
      chk("pop_strobe_lsb", 32'(fout_l), 32'(!exp_pop));
      chk("clear_strobe", 32'(fclr_m), 32'(!(RstN && !FlushN)));
      do_pop = !fout_m;
      do_clr = !fclr_m;
      head   = F_Data;
      if (RstN && FlushN && valid_m && B_Ready) begin
         log_m.push_back(data_m);
         log_l.push_back(data_l);
         log_last.push_back(last_m);
         if (first_acc < 0) first_acc = tick_no;
         last_acc = tick_no;
      end
      @(posedge Clk);
      if (do_clr) fifo_q.delete();
      else if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (do_pop) pops++;
      if (!RstN) begin
         m_held = 0; m_idx = 0; m_count = '0;
      end else if (!FlushN) begin
         m_held = 0; m_idx = 0;
      end else if (m_held) begin
         if (B_Ready) begin
            if (m_idx == NB - 1) begin
               m_count++;
               m_idx = 0;
               if (exp_pop) m_word = head;
               else m_held = 0;
            end else begin
               m_idx++;
            end
         end
      end else if (exp_pop) begin
         m_held = 1; m_word = head; m_idx = 0;
      end
      tick_no++;
      @(negedge Clk);
      chk("valid", 32'(valid_m), 32'(m_held));
      chk("valid_lsb", 32'(valid_l), 32'(m_held));
      chk("busy", 32'(busy_m), 32'(m_held));
      chk("last", 32'(last_m), 32'(m_held && m_idx == NB - 1));
      chk("words_sent", 32'(sent_m), 32'(m_count));
      chk("words_sent_lsb", 32'(sent_l), 32'(m_count));
      if (m_held) begin
         chk("data_msb", 32'(data_m), 32'(beat_msb(m_word, m_idx)));
         chk("data_lsb", 32'(data_l), 32'(beat_lsb(m_word, m_idx)));
      end
   endtask

   initial begin
      logic [7:0] exp_seq[4];
      RstN = 1'b0; En = 1'b1; FlushN = 1'b1; B_Ready = 1'b0;
      F_Data = '0; F_EmptyN = 1'b0;
      m_held = 0; m_word = '0; m_idx = 0; m_count = '0; tick_no = 0;
      clear_logs();

      // Reset state
      repeat (2) tick();
      chk("reset_data", 32'(data_m), 32'h0);
      chk("reset_fout", 32'(fout_m), 32'h1);
      RstN = 1'b1;

      // Single word, MSB first
      clear_logs();
      fifo_q.push_back(32'hA1B2C3D4);
      B_Ready = 1'b1;
      repeat (7) tick();
      exp_seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      chk("s1_beats", 32'(log_m.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < log_m.size()) begin
            chk("s1_beat", 32'(log_m[i]), 32'(exp_seq[i]));
            chk("s1_last", 32'(log_last[i]), 32'(i == 3));
         end
      end
      chk("s1_pops", 32'(pops), 32'd1);
      chk("s1_sent", 32'(sent_m), 32'd1);

      // Four words back-to-back
      clear_logs();
      for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
      repeat (20) tick();
      chk("s2_pops", 32'(pops), 32'd4);
      chk("s2_beats", 32'(log_m.size()), 32'd16);
      chk("s2_no_gap", 32'(last_acc - first_acc + 1), 32'd16);
      chk("s2_sent", 32'(sent_m), 32'd5);

      // Stall on beat 2
      fifo_q.push_back(32'h11223344);
      repeat (3) tick();
      B_Ready = 1'b0;
      repeat (5) tick();
      chk("s3_hold_data", 32'(data_m), 32'h33);
      chk("s3_hold_data_lsb", 32'(data_l), 32'h22);
      chk("s3_hold_valid", 32'(valid_m), 32'h1);
      chk("s3_hold_last", 32'(last_m), 32'h0);
      B_Ready = 1'b1;
      repeat (4) tick();
      chk("s3_sent", 32'(sent_m), 32'd6);

      // Flush during beat 1 of the second word
      fifo_q.push_back(32'hCAFE0001);
      fifo_q.push_back(32'hCAFE0002);
      fifo_q.push_back(32'hCAFE0003);
      repeat (6) tick();
      chk("s4_pre_flush", 32'(data_m), 32'hFE);
      FlushN = 1'b0;
      tick();
      FlushN = 1'b1;
      chk("s4_valid", 32'(valid_m), 32'h0);
      chk("s4_fifo_empty", 32'(fifo_q.size()), 32'd0);
      chk("s4_sent", 32'(sent_m), 32'd7);

      // En dropped during beat 0 with two words queued
      clear_logs();
      for (int i = 0; i < 3; i++) fifo_q.push_back(32'h5A5A0000 + 32'(i));
      tick();
      En = 1'b0;
      repeat (8) tick();
      chk("s5_fifo_held", 32'(fifo_q.size()), 32'd2);
      chk("s5_idle", 32'(valid_m), 32'h0);
      chk("s5_pops", 32'(pops), 32'd1);
      chk("s5_sent", 32'(sent_m), 32'd8);
      En = 1'b1;
      repeat (10) tick();
      chk("s5_drained", 32'(fifo_q.size()), 32'd0);
      chk("s5_sent_after", 32'(sent_m), 32'd10);

      // Reset mid-word, then LSB-first rerun of the single word
      fifo_q.push_back(32'hA1B2C3D4);
      repeat (3) tick();
      fifo_q.push_back(32'h0BADF00D);
      RstN = 1'b0;
      #1;
      chk("s6_valid", 32'(valid_m), 32'h0);
      chk("s6_data", 32'(data_m), 32'h0);
      chk("s6_last", 32'(last_m), 32'h0);
      chk("s6_busy", 32'(busy_m), 32'h0);
      chk("s6_sent", 32'(sent_m), 32'h0);
      chk("s6_fout", 32'(fout_m), 32'h1);
      repeat (2) tick();
      fifo_q.delete();
      RstN = 1'b1;
      clear_logs();
      fifo_q.push_back(32'hA1B2C3D4);
      repeat (7) tick();
      exp_seq = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      chk("s6_beats", 32'(log_l.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < log_l.size()) chk("s6_lsb_beat", 32'(log_l[i]), 32'(exp_seq[i]));
      end
      chk("s6_sent_after", 32'(sent_l), 32'd1);

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         En      = ($urandom_range(0, 9) != 0);
         B_Ready = ($urandom_range(0, 9) < 7);
         FlushN  = ($urandom_range(0, 39) != 0);
         if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) fifo_q.push_back($urandom);
         tick();
      end
      FlushN = 1'b1; En = 1'b1; B_Ready = 1'b1;
      repeat (40) tick();
      chk("final_drained", 32'(fifo_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
